// File: rtl/dt_pkg.sv
// Shared types for the distance-transform controller: FSM states, RAM owner codes
// and result-RAM widths.
package dt_pkg;

    localparam int RES_AW = 14;
    localparam int RES_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_INIT_DR,
        ST_FWD,
        ST_FWD_DR,
        ST_BWD,
        ST_BWD_DR,
        ST_FIN
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INIT,
        OWN_FWD,
        OWN_BWD
    } owner_t;

    // An engine keeps the RAM through its drain window.
    function automatic owner_t owner_of(input state_t s);
        owner_t o;
        case (s)
            ST_INIT, ST_INIT_DR: o = OWN_INIT;
            ST_FWD,  ST_FWD_DR:  o = OWN_FWD;
            ST_BWD,  ST_BWD_DR:  o = OWN_BWD;
            default:             o = OWN_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dt_res_mux.sv
// Result-RAM port mux: routes the owning engine's access to the shared RAM port,
// idle (all zero) when nobody owns it.
module dt_res_mux
    import dt_pkg::*;
(
    input  owner_t            owner,
    input  logic [RES_AW-1:0] addr_init,
    input  logic [RES_AW-1:0] addr_for,
    input  logic [RES_AW-1:0] addr_back,
    input  logic [RES_DW-1:0] do_init,
    input  logic [RES_DW-1:0] do_for,
    input  logic [RES_DW-1:0] do_back,
    input  logic              wr_init,
    input  logic              wr_for,
    input  logic              wr_back,
    input  logic              rd_init,
    input  logic              rd_for,
    input  logic              rd_back,
    output logic [RES_AW-1:0] res_addr,
    output logic [RES_DW-1:0] res_do,
    output logic              res_wr,
    output logic              res_rd
);

    always_comb begin
        res_addr = '0;
        res_do   = '0;
        res_wr   = 1'b0;
        res_rd   = 1'b0;
        case (owner)
            OWN_INIT: begin
                res_addr = addr_init;
                res_do   = do_init;
                res_wr   = wr_init;
                res_rd   = rd_init;
            end
            OWN_FWD: begin
                res_addr = addr_for;
                res_do   = do_for;
                res_wr   = wr_for;
                res_rd   = rd_for;
            end
            OWN_BWD: begin
                res_addr = addr_back;
                res_do   = do_back;
                res_wr   = wr_back;
                res_rd   = rd_back;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dt_ctrl.sv
// Distance-transform sequencer: INIT -> FWD -> BWD with drain windows and RAM arbitration.
// Optional per-phase watchdog compiled in with DT_WATCHDOG_EN.
module dt_ctrl
    import dt_pkg::*;
#(
    parameter int unsigned DRAIN_CYC  = 1,
    parameter logic [19:0] WDOG_LIMIT = 20'hFFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sti_ready,
    output logic              init_en,
    output logic              for_en,
    output logic              back_en,
    input  logic              init_done,
    input  logic              for_done,
    input  logic              back_done,
    input  logic [RES_AW-1:0] res_addr_init,
    input  logic [RES_AW-1:0] res_addr_for,
    input  logic [RES_AW-1:0] res_addr_back,
    input  logic [RES_DW-1:0] res_do_init,
    input  logic [RES_DW-1:0] res_do_for,
    input  logic [RES_DW-1:0] res_do_back,
    input  logic              res_wr_init,
    input  logic              res_wr_for,
    input  logic              res_wr_back,
    input  logic              res_rd_init,
    input  logic              res_rd_for,
    input  logic              res_rd_back,
    output logic [RES_AW-1:0] res_addr,
    output logic [RES_DW-1:0] res_do,
    output logic              res_wr,
    output logic              res_rd,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYC - 1);

    state_t     state;
    state_t     state_n;
    owner_t     owner;
    logic       sti_prev;
    logic [2:0] drain_cnt;
    logic       phase_active;
    logic       in_drain;
    logic       drain_last;
    logic       state_chg;
    logic       wdog_hit;

    assign phase_active = (state == ST_INIT) || (state == ST_FWD) ||
                          (state == ST_BWD);
    assign in_drain     = (state == ST_INIT_DR) || (state == ST_FWD_DR) ||
                          (state == ST_BWD_DR);
    assign drain_last   = (drain_cnt == DRAIN_LAST);
    assign state_chg    = (state_n != state);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (sti_ready && !sti_prev) state_n = ST_INIT;
            ST_INIT:    if (init_done) state_n = ST_INIT_DR;
            ST_INIT_DR: if (drain_last) state_n = ST_FWD;
            ST_FWD:     if (for_done) state_n = ST_FWD_DR;
            ST_FWD_DR:  if (drain_last) state_n = ST_BWD;
            ST_BWD:     if (back_done) state_n = ST_BWD_DR;
            ST_BWD_DR:  if (drain_last) state_n = ST_FIN;
            ST_FIN:     state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
        // A stuck phase is abandoned without a done pulse.
        if (wdog_hit) state_n = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            sti_prev  <= 1'b0;
            drain_cnt <= 3'd0;
        end else begin
            state    <= state_n;
            owner    <= owner_of(state_n);
            sti_prev <= sti_ready;
            if (state_chg)
                drain_cnt <= 3'd0;
            else if (in_drain)
                drain_cnt <= drain_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_en <= 1'b0;
            for_en  <= 1'b0;
            back_en <= 1'b0;
            done    <= 1'b0;
        end else begin
            init_en <= (state == ST_INIT);
            for_en  <= (state == ST_FWD);
            back_en <= (state == ST_BWD);
            done    <= (state == ST_FIN);
        end
    end

`ifdef DT_WATCHDOG_EN
    logic [19:0] wdog_cnt;
    logic        err_q;

    assign wdog_hit = phase_active && (wdog_cnt == WDOG_LIMIT);
    assign err      = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt <= 20'd0;
            err_q    <= 1'b0;
        end else begin
            if (state_chg)
                wdog_cnt <= 20'd0;
            else if (phase_active)
                wdog_cnt <= wdog_cnt + 20'd1;
            if (wdog_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign err      = (WDOG_LIMIT == 20'd0) && 1'b0;
`endif

    dt_res_mux u_mux (
        .owner     (owner),
        .addr_init (res_addr_init),
        .addr_for  (res_addr_for),
        .addr_back (res_addr_back),
        .do_init   (res_do_init),
        .do_for    (res_do_for),
        .do_back   (res_do_back),
        .wr_init   (res_wr_init),
        .wr_for    (res_wr_for),
        .wr_back   (res_wr_back),
        .rd_init   (res_rd_init),
        .rd_for    (res_rd_for),
        .rd_back   (res_rd_back),
        .res_addr  (res_addr),
        .res_do    (res_do),
        .res_wr    (res_wr),
        .res_rd    (res_rd)
    );

endmodule

// File: tb/tb_dt_ctrl.sv
// Bench for dt_ctrl: runs are modelled as phase windows computed from the phase
// lengths; RAM traffic and stray done/sti_ready levels are randomised.
module tb_dt_ctrl;
    import dt_pkg::*;

    localparam int D = 1;
`ifdef DT_WATCHDOG_EN
    localparam logic [19:0] WL = 20'd16;
`else
    localparam logic [19:0] WL = 20'hFFFFF;
`endif

    logic              clk;
    logic              reset;
    logic              sti_ready;
    logic              init_en, for_en, back_en;
    logic              init_done, for_done, back_done;
    logic [RES_AW-1:0] res_addr_init, res_addr_for, res_addr_back;
    logic [RES_DW-1:0] res_do_init, res_do_for, res_do_back;
    logic              res_wr_init, res_wr_for, res_wr_back;
    logic              res_rd_init, res_rd_for, res_rd_back;
    logic [RES_AW-1:0] res_addr;
    logic [RES_DW-1:0] res_do;
    logic              res_wr, res_rd, done, err;

    dt_ctrl #(.DRAIN_CYC(D), .WDOG_LIMIT(WL)) dut (
        .clk(clk), .reset(reset), .sti_ready(sti_ready),
        .init_en(init_en), .for_en(for_en), .back_en(back_en),
        .init_done(init_done), .for_done(for_done), .back_done(back_done),
        .res_addr_init(res_addr_init), .res_addr_for(res_addr_for),
        .res_addr_back(res_addr_back),
        .res_do_init(res_do_init), .res_do_for(res_do_for),
        .res_do_back(res_do_back),
        .res_wr_init(res_wr_init), .res_wr_for(res_wr_for),
        .res_wr_back(res_wr_back),
        .res_rd_init(res_rd_init), .res_rd_for(res_rd_for),
        .res_rd_back(res_rd_back),
        .res_addr(res_addr), .res_do(res_do), .res_wr(res_wr), .res_rd(res_rd),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_init_en"}, 32'(init_en), 0);
        chk({tag, "_for_en"}, 32'(for_en), 0);
        chk({tag, "_back_en"}, 32'(back_en), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_res_wr"}, 32'(res_wr), 0);
        chk({tag, "_res_rd"}, 32'(res_rd), 0);
        chk({tag, "_res_addr"}, 32'(res_addr), 0);
    endtask

    // One run: phase p holds its state for dd[p] cycles starting at s[p]
    // (cycle t = period after the t-th rising edge of the run); the enable is
    // the state window delayed by one cycle, the RAM owner window is the state
    // window plus the drain, done is the cycle after FIN.
    task automatic run(input int d0, input int d1, input int d2,
                       input int rst_at, input bit hold, input bit stray);
        int s[3];
        int dd[3];
        int fin, last, own;
        logic [RES_AW-1:0] a[3];
        logic [RES_DW-1:0] dv[3];
        logic w[3];
        logic r[3];
        logic dn[3];
        logic [2:0] en;
        dd = '{d0, d1, d2};
        s[0] = 1;
        s[1] = s[0] + d0 + D;
        s[2] = s[1] + d1 + D;
        fin  = s[2] + d2 + D;
        last = hold ? fin + 8 : fin + 3;
        for (int t = 0; t <= last; t++) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                a[p]  = RES_AW'($urandom);
                dv[p] = RES_DW'($urandom);
                w[p]  = 1'($urandom);
                r[p]  = 1'($urandom);
                if (t >= s[p] && t < s[p] + dd[p])
                    dn[p] = (t == s[p] + dd[p] - 1);
                else
                    dn[p] = stray ? 1'($urandom) : 1'b0;
            end
            if (t == s[0] + d0) begin
                a[0] = 14'h3FFF;
                w[0] = 1'b1;
            end
            if (t == rst_at) w[1] = 1'b1;
            res_addr_init = a[0]; res_addr_for = a[1]; res_addr_back = a[2];
            res_do_init = dv[0]; res_do_for = dv[1]; res_do_back = dv[2];
            res_wr_init = w[0]; res_wr_for = w[1]; res_wr_back = w[2];
            res_rd_init = r[0]; res_rd_for = r[1]; res_rd_back = r[2];
            init_done = dn[0]; for_done = dn[1]; back_done = dn[2];
            if (hold || t == 0) sti_ready = 1'b1;
            else sti_ready = (t < fin) ? 1'($urandom) : 1'b0;
            if (t == rst_at) begin
                reset = 1'b1;
                #1;
                chk_all_zero("midrst");
                @(negedge clk);
                reset = 1'b0;
                sti_ready = 1'b0;
                init_done = 1'b0; for_done = 1'b0; back_done = 1'b0;
                return;
            end
            #1;
            own = -1;
            for (int p = 0; p < 3; p++) begin
                en[p] = (t - 1 >= s[p]) && (t - 1 < s[p] + dd[p]);
                if (t >= s[p] && t < s[p] + dd[p] + D) own = p;
            end
            chk("init_en", 32'(init_en), 32'(en[0]));
            chk("for_en", 32'(for_en), 32'(en[1]));
            chk("back_en", 32'(back_en), 32'(en[2]));
            chk("done", 32'(done), 32'(t == fin + 1));
            chk("err", 32'(err), 0);
            chk("res_addr", 32'(res_addr), own < 0 ? 0 : 32'(a[own]));
            chk("res_do", 32'(res_do), own < 0 ? 0 : 32'(dv[own]));
            chk("res_wr", 32'(res_wr), own < 0 ? 0 : 32'(w[own]));
            chk("res_rd", 32'(res_rd), own < 0 ? 0 : 32'(r[own]));
        end
        if (hold) begin
            @(negedge clk);
            sti_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        sti_ready = 1'b0;
        init_done = 1'b0; for_done = 1'b0; back_done = 1'b0;
        res_addr_init = '0; res_addr_for = '0; res_addr_back = '0;
        res_do_init = '0; res_do_for = '0; res_do_back = '0;
        res_wr_init = 1'b1; res_wr_for = 1'b1; res_wr_back = 1'b1;
        res_rd_init = 1'b1; res_rd_for = 1'b1; res_rd_back = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Nominal: enables at 2-11, 13-22, 24-33 and done at 35.
        run(10, 10, 10, -1, 1'b0, 1'b0);
        run(1, 1, 1, -1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++)
            run($urandom_range(1, 12), $urandom_range(1, 12),
                $urandom_range(1, 12), -1, 1'b0, 1'b1);
        run(3, 5, 4, -1, 1'b1, 1'b1);
        // Reset lands in the fourth FWD cycle (FWD starts at 1+4+D).
        run(4, 8, 6, 1 + 4 + D + 3, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk_all_zero("postrst");
        run(2, 3, 2, -1, 1'b0, 1'b1);

`ifdef DT_WATCHDOG_EN
        // INIT 1-2, drain 3, FWD from 4; counter hits 16 at cycle 20.
        for (int t = 0; t <= 30; t++) begin
            @(negedge clk);
            sti_ready = (t == 0);
            init_done = (t == 2);
            for_done  = 1'b0;
            back_done = 1'b0;
            #1;
            chk("wd_err", 32'(err), 32'(t >= 21));
            chk("wd_for_en", 32'(for_en), 32'(t >= 5 && t <= 21));
            chk("wd_back_en", 32'(back_en), 0);
            chk("wd_done", 32'(done), 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
